fetch_sequencer: RTL and testbench

- Instruction-fetch and next-PC sequencer. It produces the instruction word whose op/func fields feed the control decoder, then consumes the decoded Beq/Bne/JR/JMP/JAL/SysCall strobes to select the next PC.
- Sits between instruction memory (variable-latency req/ack) and the control decoder / register file in the multi-cycle MIPS core.
- Owns the PC, the halt-on-syscall state and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/next_pc_sel.sv | 48 ++++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types: fetch FSM states, decoder strobe bundle,
// instruction field positions and common constants.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic beq;
    logic bne;
    logic jr;
    logic jmp;
    logic jal;
    logic syscall;
  } ctrl_t;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int IMM_MSB  = 15;
  localparam int JIDX_MSB = 25;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int SYSCALL_HALT = 10;

  function automatic logic [31:0] br_off(
    input logic [IMM_MSB:0] imm
  );
    return {{14{imm[IMM_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: JR, then JMP/JAL, then taken branch,
// otherwise sequential.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0]       pc_plus4,
  input  logic [JIDX_MSB:0] jidx,
  input  ctrl_t             ctrl,
  input  logic              alu_equal,
  input  logic [31:0]       rs_data,
  output logic [31:0]       next_pc,
  output logic              misalign
);

  logic        br_taken;
  logic        sel_jr;
  logic        sel_j;
  logic        sel_br;
  logic [31:0] jr_tgt;
  logic [31:0] j_tgt;
  logic [31:0] br_tgt;

  assign br_taken = (ctrl.beq & alu_equal) |
                    (ctrl.bne & ~alu_equal);

  // one-hot selects so overlapping strobes resolve by priority
  assign sel_jr = ctrl.jr;
  assign sel_j  = ~ctrl.jr & (ctrl.jmp | ctrl.jal);
  assign sel_br = ~ctrl.jr & ~(ctrl.jmp | ctrl.jal)
                & br_taken;

  assign jr_tgt = {rs_data[31:2], 2'b00};
  assign j_tgt  = {pc_plus4[31:28], jidx, 2'b00};
  assign br_tgt = pc_plus4 + br_off(jidx[IMM_MSB:0]);

  assign misalign = ctrl.jr & (|rs_data[1:0]);

  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      sel_jr:  next_pc = jr_tgt;
      sel_j:   next_pc = j_tgt;
      sel_br:  next_pc = br_tgt;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and next-PC sequencer: owns PC, halt state
// and the retired-instruction counter.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             Beq,
  input  logic             Bne,
  input  logic             JR,
  input  logic             JMP,
  input  logic             JAL,
  input  logic             SysCall,
  input  logic             alu_equal,
  input  logic [31:0]      rs_data,
  input  logic             halt_code,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired
);

  state_t      state;
  state_t      state_n;
  logic        req_q;
  ctrl_t       ctrl;
  logic [31:0] next_pc;
  logic        jr_mis;

  assign ctrl = '{
    beq:     Beq,
    bne:     Bne,
    jr:      JR,
    jmp:     JMP,
    jal:     JAL,
    syscall: SysCall
  };

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = req_q;
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

  next_pc_sel u_npc (
    .pc_plus4  (pc_plus4),
    .jidx      (instr[JIDX_MSB:0]),
    .ctrl      (ctrl),
    .alu_equal (alu_equal),
    .rs_data   (rs_data),
    .next_pc   (next_pc),
    .misalign  (jr_mis)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH: state_n = WAIT;
      WAIT:  if (imem_ack) state_n = EXEC;
      EXEC: begin
        if (SysCall & halt_code) state_n = HALT;
        else                     state_n = FETCH;
      end
      HALT:  if (resume) state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      req_q <= 1'b0;
    end else begin
      state <= state_n;
      // registered so the request stays low in the reset cycle
      req_q <= (state_n == FETCH) || (state_n == WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      instr        <= NOP;
      misalign_err <= 1'b0;
      retired      <= '0;
    end else begin
      if (state == WAIT && imem_ack)
        instr <= imem_rdata;
      if (state == EXEC) begin
        pc      <= next_pc;
        retired <= retired + CNT_W'(1);
        if (jr_mis)
          misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer, with hand sequences
// for halt/resume, mid-wait reset and counter wrap.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        Beq, Bne, JR, JMP, JAL, SysCall;
  logic        alu_equal;
  logic [31:0] rs_data;
  logic        halt_code;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misalign_err;
  logic [3:0]  retired;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .Beq(Beq), .Bne(Bne), .JR(JR), .JMP(JMP), .JAL(JAL),
    .SysCall(SysCall), .alu_equal(alu_equal),
    .rs_data(rs_data), .halt_code(halt_code),
    .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .misalign_err(misalign_err),
    .retired(retired)
  );

  typedef struct {
    logic [31:0] word;
    int          lat;
    logic [5:0]  stb;
    logic        eq;
    logic [31:0] rs;
    logic        hc;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] cur_pc;
  int exp_ret;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    {Beq, Bne, JR, JMP, JAL, SysCall} = 6'b0;
    alu_equal = 1'b0;
    rs_data   = 32'h0;
    halt_code = 1'b0;
    resume    = 1'b0;
    imem_ack  = 1'b0;
  endtask

  // starts in FETCH, ends one clock after EXEC
  task automatic run(input vec_t v, input bit first);
    if (!first) chk("fetch_req", {31'b0, imem_req}, 1);
    chk("fetch_addr", imem_addr, cur_pc);
    @(posedge clk); #1;
    chk("wait_req", {31'b0, imem_req}, 1);
    resume = 1'b1;
    for (int i = 0; i < v.lat; i++) begin
      chk("wait_valid", {31'b0, instr_valid}, 0);
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = v.word;
    @(posedge clk); #1;
    imem_rdata = ~v.word;
    {Beq, Bne, JR, JMP, JAL, SysCall} = v.stb;
    alu_equal = v.eq;
    rs_data   = v.rs;
    halt_code = v.hc;
    #1;
    chk("exec_valid", {31'b0, instr_valid}, 1);
    chk("exec_req", {31'b0, imem_req}, 0);
    chk("exec_instr", instr, v.word);
    chk("exec_pc4", pc_plus4, cur_pc + 32'd4);
    @(posedge clk); #1;
    clr_in();
    exp_ret++;
    chk("next_pc", pc, v.exp_pc);
    chk("instr_hold", instr, v.word);
    chk("valid_drop", {31'b0, instr_valid}, 0);
    chk("misalign", {31'b0, misalign_err}, {31'b0, v.exp_mis});
    chk("retired", {28'b0, retired}, exp_ret & 15);
    cur_pc = v.exp_pc;
  endtask

  // stb order: {beq,bne,jr,jmp,jal,syscall}
  vec_t vecs[18];

  initial begin
    int bad;
    vec_t nop;
    vecs[0]  = '{32'h0000_0000, 3, 6'b000000, 0, 0, 0, 32'h0000_0004, 0};
    vecs[1]  = '{32'h0000_0008, 1, 6'b001000, 0, 32'h100, 0, 32'h0000_0100, 0};
    vecs[2]  = '{32'h1000_FFFF, 0, 6'b100000, 1, 0, 0, 32'h0000_0100, 0};
    vecs[3]  = '{32'h1400_0003, 2, 6'b010000, 0, 0, 0, 32'h0000_0110, 0};
    vecs[4]  = '{32'h0000_0008, 0, 6'b001000, 0, 32'h100, 0, 32'h0000_0100, 0};
    vecs[5]  = '{32'h1000_FFFF, 1, 6'b100000, 0, 0, 0, 32'h0000_0104, 0};
    vecs[6]  = '{32'h1400_0003, 0, 6'b010000, 1, 0, 0, 32'h0000_0108, 0};
    vecs[7]  = '{32'h0000_0008, 0, 6'b001000, 0, 32'h1000_0008, 0, 32'h1000_0008, 0};
    vecs[8]  = '{32'h0C00_0040, 2, 6'b000010, 0, 0, 0, 32'h1000_0100, 0};
    vecs[9]  = '{32'h0800_0040, 0, 6'b001100, 0, 32'h200, 0, 32'h0000_0200, 0};
    vecs[10] = '{32'h0800_0100, 1, 6'b100100, 1, 0, 0, 32'h0000_0400, 0};
    vecs[11] = '{32'h0000_000C, 0, 6'b000001, 0, 0, 0, 32'h0000_0404, 0};
    vecs[12] = '{32'h0000_0008, 0, 6'b001000, 0, 32'h203, 0, 32'h0000_0200, 1};
    vecs[13] = '{32'h0000_0000, 2, 6'b000000, 0, 0, 0, 32'h0000_0204, 1};
    vecs[14] = '{32'h0000_0008, 0, 6'b001000, 0, 32'h40, 0, 32'h0000_0040, 1};
    vecs[15] = '{32'h0000_000C, 1, 6'b000001, 0, 0, 1, 32'h0000_0044, 1};
    vecs[16] = '{32'h0000_0008, 0, 6'b001000, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1};
    vecs[17] = '{32'h0000_0000, 0, 6'b000000, 0, 0, 0, 32'h0000_0000, 1};
    nop = '{32'h0, 0, 6'b0, 0, 0, 0, 32'h0, 0};

    clr_in();
    imem_rdata = 32'h0;
    rst_n = 1'b0;
    cur_pc = 32'h0;
    exp_ret = 0;
    #12;
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_retired", {28'b0, retired}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_req", {31'b0, imem_req}, 0);

    for (int i = 0; i < 18; i++) begin
      run(vecs[i], i == 0);
      if (i == 15) begin
        chk("halted", {31'b0, halted}, 1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (imem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk("halt_quiet", bad, 0);
        chk("halt_pc", pc, 32'h44);
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        chk("resume_halted", {31'b0, halted}, 0);
      end
    end

    // reset while waiting for a response
    @(posedge clk); #1;
    chk("mid_wait_req", {31'b0, imem_req}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req}, 0);
    chk("async_mis", {31'b0, misalign_err}, 0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_instr", instr, 32'h0);
    chk("rst2_pc", pc, 32'h0);
    exp_ret = 0;
    cur_pc  = 32'h0;
    for (int i = 0; i < 16; i++) begin
      nop.exp_pc = cur_pc + 32'd4;
      run(nop, i == 0);
    end
    chk("wrap_retired", {28'b0, retired}, 0);
    chk("wrap_pc", pc, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
